// File: rtl/ex_lsu_pkg.sv
// Shared definitions for the EX-stage load/store issue logic: op one-hot bit
// positions, load-bus width, issue FSM encodings and stall polarity.
package ex_lsu_pkg;

   localparam int STALL_W    = 6;
   localparam int OP_W       = 8;
   localparam int LOAD_BUS_W = 5;

   // id_mem_op is one-hot {lb,lbu,lh,lhu,lw,sb,sh,sw}, lb in the MSB
   localparam int OP_LB  = 7;
   localparam int OP_LBU = 6;
   localparam int OP_LH  = 5;
   localparam int OP_LHU = 4;
   localparam int OP_LW  = 3;
   localparam int OP_SB  = 2;
   localparam int OP_SH  = 1;
   localparam int OP_SW  = 0;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

endpackage

// File: rtl/ex_lsu_lane_gen.sv
// Byte-lane select and store-data replication from the low address bits and op.
// Low bits are forced to natural alignment so misaligned halves/words still map to valid lanes.
module lsu_lane_gen
   import ex_lsu_pkg::*;
(
   input  logic [OP_W-1:0] op,
   input  logic [1:0]      ea_lo,
   input  logic [31:0]     store_data,
   output logic [3:0]      sel,
   output logic [3:0]      wen,
   output logic [31:0]     wdata
);

   logic is_byte, is_half, is_word, is_store;

   assign is_byte  = op[OP_LB] | op[OP_LBU] | op[OP_SB];
   assign is_half  = op[OP_LH] | op[OP_LHU] | op[OP_SH];
   assign is_word  = op[OP_LW] | op[OP_SW];
   assign is_store = op[OP_SB] | op[OP_SH] | op[OP_SW];

   always_comb begin
      sel   = 4'b0000;
      wdata = store_data;
      if (is_byte)
         sel = 4'b0001 << ea_lo;
      else if (is_half)
         sel = ea_lo[1] ? 4'b1100 : 4'b0011;
      else if (is_word)
         sel = 4'b1111;
      if (op[OP_SB])
         wdata = {4{store_data[7:0]}};
      else if (op[OP_SH])
         wdata = {2{store_data[15:0]}};
   end

   assign wen = is_store ? sel : 4'b0000;

endmodule

// File: rtl/ex_lsu.sv
// EX-stage load/store issue: latches the ID memory op, forms the effective address,
// drives the data SRAM request/grant handshake and raises load-use / memory stalls.
// Build option: define UNALIGNED_EXC_EN to flag misaligned accesses instead of masking them.
module ex_lsu
   import ex_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LOAD_W = LOAD_BUS_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic [OP_W-1:0]    id_mem_op,
   input  logic [ADDR_W-1:0]  id_base,
   input  logic [15:0]        id_offset,
   input  logic [31:0]        id_store_data,
   input  logic [4:0]         id_rf_waddr,
   input  logic [4:0]         id_rs,
   input  logic [4:0]         id_rt,
   input  logic               id_rs_re,
   input  logic               id_rt_re,
   input  logic               data_sram_gnt,
   output logic               data_sram_en,
   output logic [3:0]         data_sram_wen,
   output logic [ADDR_W-1:0]  data_sram_addr,
   output logic [31:0]        data_sram_wdata,
   output logic [3:0]         data_ram_sel,
   output logic [LOAD_W-1:0]  ex_load_bus,
   output logic [ADDR_W-1:0]  ex_mem_addr,
   output logic [1:0]         addr_exc,
   output logic               stallreq_for_load,
   output logic               stallreq_for_mem
);

   logic [OP_W-1:0]   op_r;
   logic [ADDR_W-1:0] base_r;
   logic [15:0]       offset_r;
   logic [31:0]       store_data_r;
   logic [4:0]        rf_waddr_r;
   lsu_state_e        state_r;

   logic [ADDR_W-1:0] ea;
   logic              is_load, is_store, misaligned, adel, ades, exc, op_valid, advance;
   logic [3:0]        sel_raw, wen_raw;
   logic              unused_stall;

   assign unused_stall = ^{stall[STALL_W-1:4], stall[1:0]};
   assign advance      = (stall[3] == NO_STOP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r         <= '0;
         base_r       <= '0;
         offset_r     <= '0;
         store_data_r <= '0;
         rf_waddr_r   <= '0;
      end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
         op_r         <= '0;
         base_r       <= '0;
         offset_r     <= '0;
         store_data_r <= '0;
         rf_waddr_r   <= '0;
      end else if (stall[2] == NO_STOP) begin
         op_r         <= id_mem_op;
         base_r       <= id_base;
         offset_r     <= id_offset;
         store_data_r <= id_store_data;
         rf_waddr_r   <= id_rf_waddr;
      end
   end

   assign ea       = base_r + {{(ADDR_W-16){offset_r[15]}}, offset_r};
   assign is_load  = |op_r[OP_LB:OP_LW];
   assign is_store = |op_r[OP_SB:OP_SW];

   assign misaligned = ((op_r[OP_LH] | op_r[OP_LHU] | op_r[OP_SH]) & ea[0])
                     | ((op_r[OP_LW] | op_r[OP_SW]) & (|ea[1:0]));

`ifdef UNALIGNED_EXC_EN
   assign adel = is_load & misaligned;
   assign ades = is_store & misaligned;
`else
   assign adel = 1'b0;
   assign ades = 1'b0;
   logic unused_misaligned;
   assign unused_misaligned = misaligned;
`endif

   assign exc      = adel | ades;
   assign op_valid = (|op_r) & ~exc;

   lsu_lane_gen u_lane_gen (
      .op         (op_r),
      .ea_lo      (ea[1:0]),
      .store_data (store_data_r),
      .sel        (sel_raw),
      .wen        (wen_raw),
      .wdata      (data_sram_wdata)
   );

   // A granted request parked in DONE must not re-assert en, or a store would repeat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: if (op_valid) begin
               if (data_sram_gnt) state_r <= advance ? ST_IDLE : ST_DONE;
               else               state_r <= ST_WAIT;
            end
            ST_WAIT: if (data_sram_gnt) state_r <= advance ? ST_IDLE : ST_DONE;
            ST_DONE: if (advance) state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign data_sram_en     = ((state_r == ST_IDLE) & op_valid) | (state_r == ST_WAIT);
   assign stallreq_for_mem = ((state_r == ST_IDLE) & op_valid & ~data_sram_gnt)
                           | (state_r == ST_WAIT);

   assign data_sram_addr = {ea[ADDR_W-1:2], 2'b00};
   assign data_ram_sel   = exc ? 4'b0000 : sel_raw;
   assign data_sram_wen  = exc ? 4'b0000 : wen_raw;
   assign ex_load_bus    = exc ? '0 : LOAD_W'(op_r[OP_LB:OP_LW]);
   assign ex_mem_addr    = ea;
   assign addr_exc       = {adel, ades};

   assign stallreq_for_load = is_load & (rf_waddr_r != 5'd0)
                            & ((id_rs_re & (id_rs == rf_waddr_r)) | (id_rt_re & (id_rt == rf_waddr_r)));

endmodule
